mips_mc_control: RTL and testbench

Parametrised multicycle MIPS control unit; successor to the current fixed-latency controller in the multicycle core. Decodes `Opcode`/`Funct` from the instruction register into datapath mux selects and write strobes. Generates `PCEn` internally from branch condition and `zero`, and adds bne, andi, j, jal, jr, illegal-op detection and a retired-instruction counter. `MEM_WAIT` stretches every memory-access state, so the core can run on slower memories without datapath changes.

---
 rtl/mips_mc_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: decodes Opcode/Funct into datapath selects and strobes.
// Memory states (FETCH, MEMRD, MEMWR) are stretched by MEM_WAIT cycles; counts retired instructions.
module mips_mc_control #(
  parameter int MEM_WAIT  = 0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 zero,
  output logic                 PCEn,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic                 Ori,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic [1:0]           MemtoReg,
  output logic [1:0]           RegDst,
  output logic [2:0]           ALUControl,
  output logic                 InstrDone,
  output logic                 Illegal,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_ALUWB_R, S_EXEC_I, S_ALUWB_I, S_BRANCH, S_JUMP, S_JR
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e               state_q, state_d;
  logic [3:0]           wait_q, wait_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 wait_done;
  logic                 funct_alu_ok;
  logic [2:0]           funct_alu;

  // The counter only advances inside a memory state and clears on exit,
  // so every memory state is entered with wait_q == 0.
  assign wait_done  = (wait_q == WAIT_LAST);
  assign InstrCount = cnt_q;

  always_comb begin
    funct_alu_ok = 1'b1;
    funct_alu    = ALU_ADD;
    case (Funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    Ori        = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    MemtoReg   = 2'b00;
    RegDst     = 2'b00;
    ALUControl = ALU_ADD;
    InstrDone  = 1'b0;
    Illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        if (wait_done) begin
          IRWrite = 1'b1;
          PCEn    = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        state_d = S_FETCH;
        case (Opcode)
          OP_RTYPE: begin
            if (Funct == FN_JR)    state_d = S_JR;
            else if (funct_alu_ok) state_d = S_EXEC_R;
            else                   Illegal = 1'b1;
          end
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J, OP_JAL:            state_d = S_JUMP;
          default:                 Illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (wait_done) state_d = S_MEMWB;
        else           wait_d  = wait_q + 4'd1;
      end
      S_MEMWB: begin
        MemtoReg  = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        IorD = 1'b1;
        if (wait_done) begin
          MemWrite  = 1'b1;
          InstrDone = 1'b1;
          state_d   = S_FETCH;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        state_d    = S_ALUWB_R;
      end
      S_ALUWB_R: begin
        RegDst    = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB_I;
        case (Opcode)
          OP_ANDI: begin ALUControl = ALU_AND; Ori = 1'b1; end
          OP_ORI:  begin ALUControl = ALU_OR;  Ori = 1'b1; end
          default: ALUControl = ALU_ADD;
        endcase
      end
      S_ALUWB_I: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        PCEn       = (Opcode == OP_BNE) ? ~zero : zero;
        InstrDone  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        PCEn      = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
        if (Opcode == OP_JAL) begin
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
          RegWrite = 1'b1;
        end
      end
      S_JR: begin
        PCSrc     = 2'b11;
        PCEn      = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts the instruction: no strobes, selects parked at FETCH values.
    if (rst) begin
      PCEn       = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      Ori        = 1'b0;
      ALUSrcB    = 2'b01;
      PCSrc      = 2'b00;
      MemtoReg   = 2'b00;
      RegDst     = 2'b00;
      ALUControl = ALU_ADD;
      InstrDone  = 1'b0;
      Illegal    = 1'b0;
    end
  end

  assign cnt_d = cnt_q + CNT_WIDTH'(InstrDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: four instances (MEM_WAIT 0/2/3, CNT_WIDTH 32/2) checked per cycle
// against hand-written expected-output tables; unselected instances are held in reset.
module tb_mips_mc_control;

  typedef struct packed {
    logic       pcen, iord, irw, mw, rw, sa, ori;
    logic [1:0] sb, ps, m2r, rd;
    logic [2:0] alu;
    logic       dn, il;
  } out_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    out_t       exp;
  } vec_t;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] F0      = 6'b000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [3:0]  rst_a;
  logic [5:0]  op, fn;
  logic        z;
  out_t        o_a [4];
  logic [31:0] c_a [4];
  out_t        obs;
  logic [31:0] cnt_obs;
  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_bad = 0;

  out_t FL, FW, DEC, ILL, MADR, MRD, MWB, MWRL, WBR, WBI;
  out_t XR_ADD, XR_SUB, XR_AND, XR_OR, XR_SLT, XI_ADD, XI_AND, XI_OR;
  out_t BRT, BRN, JMP, JAL, JR;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 1) ? 2 : (g == 2) ? 3 : 0;
    localparam int C = (g == 3) ? 2 : 32;
    logic [C-1:0] cnt;
    logic         pcen, iord, irw, mw, rw, sa, ori, dn, il;
    logic [1:0]   sb, ps, m2r, rd;
    logic [2:0]   alu;
    mips_mc_control #(.MEM_WAIT(W), .CNT_WIDTH(C)) u_dut (
      .clk(clk), .rst(rst_a[g]), .Opcode(op), .Funct(fn), .zero(z),
      .PCEn(pcen), .IorD(iord), .IRWrite(irw), .MemWrite(mw), .RegWrite(rw),
      .ALUSrcA(sa), .Ori(ori), .ALUSrcB(sb), .PCSrc(ps), .MemtoReg(m2r),
      .RegDst(rd), .ALUControl(alu), .InstrDone(dn), .Illegal(il),
      .InstrCount(cnt));
    assign o_a[g] = {pcen, iord, irw, mw, rw, sa, ori, sb, ps, m2r, rd, alu, dn, il};
    assign c_a[g] = 32'(cnt);
  end

  always_comb begin
    rst_a = 4'b1111;
    for (int k = 0; k < 4; k++) rst_a[k] = (sel == k[1:0]) ? rst : 1'b1;
  end

  assign obs     = o_a[sel];
  assign cnt_obs = c_a[sel];

  function automatic out_t mk(input logic pcen, iord, irw, mw, rw, sa, ori,
                              input logic [1:0] sb, ps, m2r, rd,
                              input logic [2:0] alu, input logic dn, il);
    mk = {pcen, iord, irw, mw, rw, sa, ori, sb, ps, m2r, rd, alu, dn, il};
  endfunction

  task automatic chk(input string tag, input int idx, input out_t exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: outputs got %05h expected %05h", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    n_vec++;
    if (cnt_obs !== exp) begin
      n_bad++;
      $display("FAIL %s: InstrCount got %0d expected %0d", tag, cnt_obs, exp);
    end
  endtask

  task automatic v(input logic [5:0] o, input logic [5:0] f, input logic zz, input out_t e);
    tbl.push_back({o, f, zz, e});
  endtask

  // Fetch phase: w wait cycles then the IRWrite/PCEn cycle.
  task automatic fe(input logic [5:0] o, input logic [5:0] f, input logic zz, input int w);
    for (int i = 0; i < w; i++) v(o, f, zz, FW);
    v(o, f, zz, FL);
  endtask

  // Entered just after a rising edge; each row is one clock cycle.
  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      op = tbl[i].op;
      fn = tbl[i].fn;
      z  = tbl[i].z;
      @(negedge clk);
      chk(tag, i, tbl[i].exp);
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  task automatic do_reset(input logic [1:0] s);
    sel = s;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    //        pcen iord irw mw rw sa ori  sb     ps     m2r    rd     alu   dn il
    FL     = mk(H, L, H, L, L, L, L, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, L, L);
    FW     = mk(L, L, L, L, L, L, L, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, L, L);
    DEC    = mk(L, L, L, L, L, L, L, 2'b11, 2'b00, 2'b00, 2'b00, 3'b010, L, L);
    ILL    = mk(L, L, L, L, L, L, L, 2'b11, 2'b00, 2'b00, 2'b00, 3'b010, L, H);
    MADR   = mk(L, L, L, L, L, H, L, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, L, L);
    MRD    = mk(L, H, L, L, L, L, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, L, L);
    MWB    = mk(L, L, L, L, H, L, L, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, H, L);
    MWRL   = mk(L, H, L, H, L, L, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, H, L);
    WBR    = mk(L, L, L, L, H, L, L, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, H, L);
    WBI    = mk(L, L, L, L, H, L, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, H, L);
    XR_ADD = mk(L, L, L, L, L, H, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, L, L);
    XR_SUB = mk(L, L, L, L, L, H, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b110, L, L);
    XR_AND = mk(L, L, L, L, L, H, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, L, L);
    XR_OR  = mk(L, L, L, L, L, H, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, L, L);
    XR_SLT = mk(L, L, L, L, L, H, L, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, L, L);
    XI_ADD = mk(L, L, L, L, L, H, L, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, L, L);
    XI_AND = mk(L, L, L, L, L, H, H, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, L, L);
    XI_OR  = mk(L, L, L, L, L, H, H, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, L, L);
    BRT    = mk(H, L, L, L, L, H, L, 2'b00, 2'b01, 2'b00, 2'b00, 3'b110, H, L);
    BRN    = mk(L, L, L, L, L, H, L, 2'b00, 2'b01, 2'b00, 2'b00, 3'b110, H, L);
    JMP    = mk(H, L, L, L, L, L, L, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, H, L);
    JAL    = mk(H, L, L, L, H, L, L, 2'b00, 2'b10, 2'b10, 2'b10, 3'b010, H, L);
    JR     = mk(H, L, L, L, L, L, L, 2'b00, 2'b11, 2'b00, 2'b00, 3'b010, H, L);

    op = OP_R; fn = F0; z = 1'b0;

    // MEM_WAIT=0: reset values, then addi/lw/sw/add with done spacing 4,5,4,4
    sel = 2'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 0, FW);
    chk_cnt("reset_cnt", 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    fe(OP_ADDI, F0, L, 0); v(OP_ADDI, F0, L, DEC); v(OP_ADDI, F0, L, XI_ADD); v(OP_ADDI, F0, L, WBI);
    fe(OP_LW, F0, L, 0);   v(OP_LW, F0, L, DEC);   v(OP_LW, F0, L, MADR);     v(OP_LW, F0, L, MRD);
    v(OP_LW, F0, L, MWB);
    fe(OP_SW, F0, L, 0);   v(OP_SW, F0, L, DEC);   v(OP_SW, F0, L, MADR);     v(OP_SW, F0, L, MWRL);
    fe(OP_R, 6'b100000, L, 0); v(OP_R, 6'b100000, L, DEC); v(OP_R, 6'b100000, L, XR_ADD);
    v(OP_R, 6'b100000, L, WBR);
    run_tbl("w0_seq");
    chk_cnt("w0_seq_cnt", 32'd4);

    // remaining R/I types, branches both ways, jumps, illegal ops
    fe(OP_R, 6'b100010, L, 0); v(OP_R, 6'b100010, L, DEC); v(OP_R, 6'b100010, L, XR_SUB); v(OP_R, 6'b100010, L, WBR);
    fe(OP_R, 6'b100100, L, 0); v(OP_R, 6'b100100, L, DEC); v(OP_R, 6'b100100, L, XR_AND); v(OP_R, 6'b100100, L, WBR);
    fe(OP_R, 6'b100101, L, 0); v(OP_R, 6'b100101, L, DEC); v(OP_R, 6'b100101, L, XR_OR);  v(OP_R, 6'b100101, L, WBR);
    fe(OP_R, 6'b101010, L, 0); v(OP_R, 6'b101010, L, DEC); v(OP_R, 6'b101010, L, XR_SLT); v(OP_R, 6'b101010, L, WBR);
    fe(OP_ANDI, F0, L, 0); v(OP_ANDI, F0, L, DEC); v(OP_ANDI, F0, L, XI_AND); v(OP_ANDI, F0, L, WBI);
    fe(OP_ORI, F0, L, 0);  v(OP_ORI, F0, L, DEC);  v(OP_ORI, F0, L, XI_OR);   v(OP_ORI, F0, L, WBI);
    fe(OP_BEQ, F0, H, 0);  v(OP_BEQ, F0, H, DEC);  v(OP_BEQ, F0, H, BRT);
    fe(OP_BEQ, F0, L, 0);  v(OP_BEQ, F0, L, DEC);  v(OP_BEQ, F0, L, BRN);
    fe(OP_BNE, F0, L, 0);  v(OP_BNE, F0, L, DEC);  v(OP_BNE, F0, L, BRT);
    fe(OP_BNE, F0, H, 0);  v(OP_BNE, F0, H, DEC);  v(OP_BNE, F0, H, BRN);
    fe(OP_J, F0, L, 0);    v(OP_J, F0, L, DEC);    v(OP_J, F0, L, JMP);
    fe(OP_JAL, F0, L, 0);  v(OP_JAL, F0, L, DEC);  v(OP_JAL, F0, L, JAL);
    fe(OP_R, 6'b001000, L, 0); v(OP_R, 6'b001000, L, DEC); v(OP_R, 6'b001000, L, JR);
    fe(OP_BAD, F0, L, 0);  v(OP_BAD, F0, L, ILL);
    fe(OP_R, 6'b000111, L, 0); v(OP_R, 6'b000111, L, ILL);
    fe(OP_ADDI, F0, L, 0); v(OP_ADDI, F0, L, DEC); v(OP_ADDI, F0, L, XI_ADD); v(OP_ADDI, F0, L, WBI);
    run_tbl("w0_ops");
    chk_cnt("w0_ops_cnt", 32'd18);

    // MEM_WAIT=2: retire addi, then reset for 3 cycles in the middle of lw's MEMRD
    do_reset(2'd1);
    fe(OP_ADDI, F0, L, 2); v(OP_ADDI, F0, L, DEC); v(OP_ADDI, F0, L, XI_ADD); v(OP_ADDI, F0, L, WBI);
    fe(OP_LW, F0, L, 2);   v(OP_LW, F0, L, DEC);   v(OP_LW, F0, L, MADR);     v(OP_LW, F0, L, MRD);
    run_tbl("w2_pre");
    chk_cnt("w2_pre_cnt", 32'd1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("w2_in_reset", k, FW);
      @(posedge clk);
      #1;
    end
    chk_cnt("w2_reset_cnt", 32'd0);
    rst = 1'b0;
    fe(OP_LW, F0, L, 2); v(OP_LW, F0, L, DEC); v(OP_LW, F0, L, MADR);
    v(OP_LW, F0, L, MRD); v(OP_LW, F0, L, MRD); v(OP_LW, F0, L, MRD); v(OP_LW, F0, L, MWB);
    run_tbl("w2_post");
    chk_cnt("w2_post_cnt", 32'd1);

    // MEM_WAIT=3: lw takes 11 cycles, sw 10
    do_reset(2'd2);
    fe(OP_LW, F0, L, 3); v(OP_LW, F0, L, DEC); v(OP_LW, F0, L, MADR);
    for (int i = 0; i < 4; i++) v(OP_LW, F0, L, MRD);
    v(OP_LW, F0, L, MWB);
    fe(OP_SW, F0, L, 3); v(OP_SW, F0, L, DEC); v(OP_SW, F0, L, MADR);
    for (int i = 0; i < 3; i++) v(OP_SW, F0, L, MRD);
    v(OP_SW, F0, L, MWRL);
    run_tbl("w3_mem");
    chk_cnt("w3_cnt", 32'd2);

    // CNT_WIDTH=2: five legal jumps around an illegal op wrap the count to 1
    do_reset(2'd3);
    for (int i = 0; i < 2; i++) begin fe(OP_J, F0, L, 0); v(OP_J, F0, L, DEC); v(OP_J, F0, L, JMP); end
    fe(OP_BAD, F0, L, 0); v(OP_BAD, F0, L, ILL);
    for (int i = 0; i < 3; i++) begin fe(OP_J, F0, L, 0); v(OP_J, F0, L, DEC); v(OP_J, F0, L, JMP); end
    run_tbl("c2_wrap");
    chk_cnt("c2_wrap_cnt", 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
